// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for 640x480 @ 60 Hz VGA on a 25 MHz pixel clock.
// Two free-running counters (hc = pixel in line, vc = line in frame) are
// exported directly as the drawing coordinate. Sync and blanking are decoded
// combinationally from those same counters so they stay aligned with it.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int CNT_W    = 10
) (
  input  logic             pixel_clk,
  input  logic             reset,
  output logic             hs,
  output logic             vs,
  output logic             active_nblank,
  output logic             sync,
  output logic [CNT_W-1:0] drawX,
  output logic [CNT_W-1:0] drawY
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries pre-sized to the counter width so every compare is width-matched.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [CNT_W-1:0] hc_next;
  logic [CNT_W-1:0] vc_next;

  // Next raster position: advance along the line, wrapping into the next line/frame.
  always_comb begin
    hc_next = hc + CNT_ONE;
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = '0;
      if (vc == V_LAST) begin
        vc_next = '0;
      end else begin
        vc_next = vc + CNT_ONE;
      end
    end else begin
      hc_next = hc + CNT_ONE;
      vc_next = vc;
    end
  end

  // Position counters; a synchronous reset returns the raster to the top-left pixel.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
    end
  end

  // Coordinate is the counters themselves: no pipeline between position and timing.
  assign drawX = hc;
  assign drawY = vc;

  // Sync pulses are active low; vs spans whole lines because it only looks at vc.
  assign hs = ~((hc >= HS_START) && (hc < HS_END));
  assign vs = ~((vc >= VS_START) && (vc < VS_END));

  assign active_nblank = (hc < H_VIS) && (vc < V_VIS);

  // Composite sync is not used by this video path.
  assign sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock and reset: the standard
// 640x480 timing, and a shrunken raster so whole frames fit in a short run.
// A reference model derives the expected coordinate/sync/blank from the number
// of clocks since the last reset, using plain division and modulo.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;

  logic       hs_b, vs_b, act_b, sync_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, act_s, sync_s;
  logic [9:0] x_s, y_s;

  int tests = 0;
  int fails = 0;

  // Small raster: 16+2+4+3 = 25 clocks per line, 12+2+2+3 = 19 lines, 475 per frame.
  vga_timing_gen dut (
    .pixel_clk(pixel_clk), .reset(reset), .hs(hs_b), .vs(vs_b),
    .active_nblank(act_b), .sync(sync_b), .drawX(x_b), .drawY(y_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CNT_W(10)
  ) dut_s (
    .pixel_clk(pixel_clk), .reset(reset), .hs(hs_s), .vs(vs_s),
    .active_nblank(act_s), .sync(sync_s), .drawX(x_s), .drawY(y_s)
  );

  always #20 pixel_clk = ~pixel_clk;

  // Expected {hs, vs, active, sync, x, y} for a clock count t after reset.
  function automatic logic [23:0] model(input int t, input int ha, input int hf,
                                        input int hsw, input int hb, input int va,
                                        input int vf, input int vsw, input int vb);
    int ht, vt, x, y;
    logic h, v, a;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x  = t % ht;
    y  = (t / ht) % vt;
    h  = !((x >= ha + hf) && (x < ha + hf + hsw));
    v  = !((y >= va + vf) && (y < va + vf + vsw));
    a  = (x < ha) && (y < va);
    return {h, v, a, 1'b0, x[9:0], y[9:0]};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Clocks elapsed since reset, per instance.
  int  t_b = 0;
  int  t_s = 0;
  logic started = 1'b0;

  // Reference clock counters: reset returns to 0, otherwise count modulo the frame.
  always @(posedge pixel_clk) begin
    started <= started | reset;
    if (reset) begin
      t_b <= 0;
      t_s <= 0;
    end else begin
      t_b <= (t_b + 1) % 420000;
      t_s <= (t_s + 1) % 475;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge pixel_clk) begin
    logic [23:0] eb, es, gb, gs;
    if (started) begin
      eb = model(t_b, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(t_s, 16, 2, 4, 3, 12, 2, 2, 3);
      gb = {hs_b, vs_b, act_b, sync_b, x_b, y_b};
      gs = {hs_s, vs_s, act_s, sync_s, x_s, y_s};
      tests += 2;
      if (gb !== eb) begin
        fails++;
        $display("FAIL model_std: got hs=%b vs=%b act=%b sync=%b x=%0d y=%0d expected hs=%b vs=%b act=%b sync=%b x=%0d y=%0d",
                 gb[23], gb[22], gb[21], gb[20], gb[19:10], gb[9:0],
                 eb[23], eb[22], eb[21], eb[20], eb[19:10], eb[9:0]);
      end
      if (gs !== es) begin
        fails++;
        $display("FAIL model_small: got hs=%b vs=%b act=%b sync=%b x=%0d y=%0d expected hs=%b vs=%b act=%b sync=%b x=%0d y=%0d",
                 gs[23], gs[22], gs[21], gs[20], gs[19:10], gs[9:0],
                 es[23], es[22], es[21], es[20], es[19:10], es[9:0]);
      end
    end
  end

  initial begin
    int cnt, low, act, first, last;
    logic prev_vs, found;

    // Reset held for four cycles: fixed idle outputs every cycle.
    repeat (4) begin
      @(negedge pixel_clk);
      check("rst_x", int'(x_b), 0);
      check("rst_y", int'(y_b), 0);
      check("rst_hs_vs_act_sync", int'({hs_b, vs_b, act_b, sync_b}), 4'b1110);
    end
    reset = 1'b0;

    // 639 edges after release: last visible pixel, then first blanked one.
    repeat (639) @(negedge pixel_clk);
    check("x_639", int'(x_b), 639);
    check("act_639", int'(act_b), 1);
    @(negedge pixel_clk);
    check("x_640", int'(x_b), 640);
    check("act_640", int'(act_b), 0);
    check("hs_640", int'(hs_b), 1);

    // Rest of line 0: hs low exactly 656..751, then wrap to (0,1).
    low = 0; first = -1; last = -1; cnt = 0;
    while (x_b != 10'd0 && cnt < 1000) begin
      @(negedge pixel_clk);
      cnt++;
      if (!hs_b) begin
        low++;
        if (first < 0) first = int'(x_b);
        last = int'(x_b);
      end
    end
    check("hs_low_clocks", low, 96);
    check("hs_first_low_x", first, 656);
    check("hs_last_low_x", last, 751);
    check("wrap_x", int'(x_b), 0);
    check("wrap_y", int'(y_b), 1);

    // Small raster: vs falls at (0, 14); one frame is 475 clocks, 192 visible, 50 vs-low.
    prev_vs = vs_s; found = 1'b0; cnt = 0;
    while (!found && cnt < 2000) begin
      @(negedge pixel_clk);
      cnt++;
      found = prev_vs && !vs_s;
      prev_vs = vs_s;
    end
    check("vs_fall_found", int'(found), 1);
    check("vs_fall_x", int'(x_s), 0);
    check("vs_fall_y", int'(y_s), 14);
    cnt = 0; act = 0; low = 0; found = 1'b0; prev_vs = vs_s;
    while (!found && cnt < 2000) begin
      act += int'(act_s);
      low += int'(!vs_s);
      cnt++;
      @(negedge pixel_clk);
      found = prev_vs && !vs_s;
      prev_vs = vs_s;
    end
    check("frame_period", cnt, 475);
    check("frame_active", act, 192);
    check("frame_vs_low", low, 50);

    // Mid-frame reset for one edge at drawX=300 of the standard raster.
    cnt = 0;
    while (x_b != 10'd300 && cnt < 1000) begin
      @(negedge pixel_clk);
      cnt++;
    end
    check("reach_x300", int'(x_b), 300);
    reset = 1'b1;
    @(negedge pixel_clk);
    reset = 1'b0;
    check("midrst_x", int'(x_b), 0);
    check("midrst_y", int'(y_b), 0);
    check("midrst_small_xy", int'({x_s, y_s}), 0);
    cnt = 0;
    while (vs_s && cnt < 1000) begin
      @(negedge pixel_clk);
      cnt++;
    end
    check("midrst_vs_delay", cnt, 14 * 25);

    // Random run lengths separated by random-length resets; the model checks every cycle.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 900)) @(negedge pixel_clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge pixel_clk);
      reset = 1'b0;
    end
    repeat (1000) @(negedge pixel_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
